// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection,
// branch flush bubbles and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_D,
  input  logic             RUWr_D,
  input  logic             AluASrc_D,
  input  logic             AluBSrc_D,
  input  logic             DMWr_D,
  input  logic             DMRd_D,
  input  logic [4:0]       BrOp_D,
  input  logic [3:0]       ALUOp_D,
  input  logic [2:0]       DMCtrl_D,
  input  logic [1:0]       RUDataWrSrc_D,
  input  logic [XLEN-1:0]  PC_D,
  input  logic [XLEN-1:0]  RUrs1_D,
  input  logic [XLEN-1:0]  RUrs2_D,
  input  logic [XLEN-1:0]  ImmExt_D,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rd_D,
  input  logic             flush_i,
  output logic             valid_E,
  output logic             RUWr_E,
  output logic             AluASrc_E,
  output logic             AluBSrc_E,
  output logic             DMWr_E,
  output logic             DMRd_E,
  output logic [4:0]       BrOp_E,
  output logic [3:0]       ALUOp_E,
  output logic [2:0]       DMCtrl_E,
  output logic [1:0]       RUDataWrSrc_E,
  output logic [XLEN-1:0]  PC_E,
  output logic [XLEN-1:0]  RUrs1_E,
  output logic [XLEN-1:0]  RUrs2_E,
  output logic [XLEN-1:0]  ImmExt_E,
  output logic [4:0]       rs1_E,
  output logic [4:0]       rs2_E,
  output logic [4:0]       rd_E,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic            ru_wr;
    logic            alu_a_src;
    logic            alu_b_src;
    logic            dm_wr;
    logic            dm_rd;
    logic [4:0]      br_op;
    logic [3:0]      alu_op;
    logic [2:0]      dm_ctrl;
    logic [1:0]      ru_data_wr_src;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_t;

  ex_t              e_q, e_d;
  logic             hazard;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both source indices are compared even when the consumer ignores rs2.
  assign hazard  = e_q.valid & e_q.dm_rd & (e_q.rd != 5'd0) & valid_D &
                   ((e_q.rd == rs1_D) | (e_q.rd == rs2_D));
  assign stall_o = hazard & ~flush_i;

  always_comb begin
    e_d = '0;
    if (!(flush_i | hazard)) begin
      // State-changing controls are gated so an empty slot is always a nop.
      e_d.valid          = valid_D;
      e_d.ru_wr          = RUWr_D & valid_D;
      e_d.alu_a_src      = AluASrc_D;
      e_d.alu_b_src      = AluBSrc_D;
      e_d.dm_wr          = DMWr_D & valid_D;
      e_d.dm_rd          = DMRd_D & valid_D;
      e_d.br_op          = valid_D ? BrOp_D : 5'd0;
      e_d.alu_op         = ALUOp_D;
      e_d.dm_ctrl        = DMCtrl_D;
      e_d.ru_data_wr_src = RUDataWrSrc_D;
      e_d.pc             = PC_D;
      e_d.rs1_data       = RUrs1_D;
      e_d.rs2_data       = RUrs2_D;
      e_d.imm            = ImmExt_D;
      e_d.rs1            = rs1_D;
      e_d.rs2            = rs2_D;
      e_d.rd             = rd_D;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid_E       = e_q.valid;
  assign RUWr_E        = e_q.ru_wr;
  assign AluASrc_E     = e_q.alu_a_src;
  assign AluBSrc_E     = e_q.alu_b_src;
  assign DMWr_E        = e_q.dm_wr;
  assign DMRd_E        = e_q.dm_rd;
  assign BrOp_E        = e_q.br_op;
  assign ALUOp_E       = e_q.alu_op;
  assign DMCtrl_E      = e_q.dm_ctrl;
  assign RUDataWrSrc_E = e_q.ru_data_wr_src;
  assign PC_E          = e_q.pc;
  assign RUrs1_E       = e_q.rs1_data;
  assign RUrs2_E       = e_q.rs2_data;
  assign ImmExt_E      = e_q.imm;
  assign rs1_E         = e_q.rs1;
  assign rs2_E         = e_q.rs2;
  assign rd_E          = e_q.rd;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and random checks of id_ex_stage against a
// scoreboard of expected execute-stage words and counter values.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int OW    = 163;

  logic clk = 1'b0;
  logic rst;
  logic valid_D, RUWr_D, AluASrc_D, AluBSrc_D, DMWr_D, DMRd_D;
  logic [4:0] BrOp_D;
  logic [3:0] ALUOp_D;
  logic [2:0] DMCtrl_D;
  logic [1:0] RUDataWrSrc_D;
  logic [XLEN-1:0] PC_D, RUrs1_D, RUrs2_D, ImmExt_D;
  logic [4:0] rs1_D, rs2_D, rd_D;
  logic flush_i;
  logic valid_E, RUWr_E, AluASrc_E, AluBSrc_E, DMWr_E, DMRd_E;
  logic [4:0] BrOp_E;
  logic [3:0] ALUOp_E;
  logic [2:0] DMCtrl_E;
  logic [1:0] RUDataWrSrc_E;
  logic [XLEN-1:0] PC_E, RUrs1_E, RUrs2_E, ImmExt_E;
  logic [4:0] rs1_E, rs2_E, rd_E;
  logic stall_o;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  logic [OW-1:0] sb[$];
  logic          m_valid, m_dmrd;
  logic [4:0]    m_rd;
  logic [CNT_W-1:0] m_stall, m_flush;
  logic [OW-1:0] out_w;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .RUWr_D(RUWr_D),
    .AluASrc_D(AluASrc_D), .AluBSrc_D(AluBSrc_D), .DMWr_D(DMWr_D), .DMRd_D(DMRd_D),
    .BrOp_D(BrOp_D), .ALUOp_D(ALUOp_D), .DMCtrl_D(DMCtrl_D), .RUDataWrSrc_D(RUDataWrSrc_D),
    .PC_D(PC_D), .RUrs1_D(RUrs1_D), .RUrs2_D(RUrs2_D), .ImmExt_D(ImmExt_D),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .flush_i(flush_i),
    .valid_E(valid_E), .RUWr_E(RUWr_E), .AluASrc_E(AluASrc_E), .AluBSrc_E(AluBSrc_E),
    .DMWr_E(DMWr_E), .DMRd_E(DMRd_E), .BrOp_E(BrOp_E), .ALUOp_E(ALUOp_E),
    .DMCtrl_E(DMCtrl_E), .RUDataWrSrc_E(RUDataWrSrc_E), .PC_E(PC_E), .RUrs1_E(RUrs1_E),
    .RUrs2_E(RUrs2_E), .ImmExt_E(ImmExt_E), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .stall_o(stall_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign out_w = {valid_E, RUWr_E, AluASrc_E, AluBSrc_E, DMWr_E, DMRd_E, BrOp_E, ALUOp_E,
                  DMCtrl_E, RUDataWrSrc_E, PC_E, RUrs1_E, RUrs2_E, ImmExt_E, rs1_E, rs2_E, rd_E};

  function automatic logic [OW-1:0] in_word();
    return {valid_D, RUWr_D & valid_D, AluASrc_D, AluBSrc_D, DMWr_D & valid_D,
            DMRd_D & valid_D, (valid_D ? BrOp_D : 5'd0), ALUOp_D, DMCtrl_D, RUDataWrSrc_D,
            PC_D, RUrs1_D, RUrs2_D, ImmExt_D, rs1_D, rs2_D, rd_D};
  endfunction

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_d();
    valid_D = 1'($urandom); RUWr_D = 1'($urandom); AluASrc_D = 1'($urandom);
    AluBSrc_D = 1'($urandom); DMWr_D = 1'($urandom); DMRd_D = 1'($urandom);
    BrOp_D = 5'($urandom); ALUOp_D = 4'($urandom); DMCtrl_D = 3'($urandom);
    RUDataWrSrc_D = 2'($urandom); PC_D = $urandom; RUrs1_D = $urandom;
    RUrs2_D = $urandom; ImmExt_D = $urandom;
    rs1_D = 5'($urandom_range(0, 7)); rs2_D = 5'($urandom_range(0, 7));
    rd_D = 5'($urandom_range(0, 7));
  endtask

  task automatic set_instr(input logic v, input logic ruwr, input logic dmrd,
                           input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] pc);
    rand_d();
    valid_D = v; RUWr_D = ruwr; DMRd_D = dmrd; DMWr_D = 1'b0; BrOp_D = 5'd0;
    ALUOp_D = 4'd0; rd_D = rd; rs1_D = rs1; rs2_D = rs2; PC_D = pc;
  endtask

  // Predict the edge from current inputs, queue the result, then check after the edge.
  task automatic tick();
    logic hz;
    logic [OW-1:0] exp;
    #2;
    hz  = m_valid & m_dmrd & (m_rd != 5'd0) & valid_D & ((m_rd == rs1_D) | (m_rd == rs2_D));
    exp = (rst | flush_i | hz) ? '0 : in_word();
    chk("stall_o", OW'(stall_o), OW'(hz & ~flush_i));
    sb.push_back(exp);
    if (rst) begin
      m_stall = '0; m_flush = '0;
    end else begin
      if (hz && !flush_i && m_stall != '1) m_stall = m_stall + 1'b1;
      if (flush_i && m_flush != '1) m_flush = m_flush + 1'b1;
    end
    m_valid = exp[OW-1]; m_dmrd = exp[OW-6]; m_rd = exp[4:0];
    @(posedge clk);
    #1;
    chk("ex_word", out_w, sb.pop_front());
    chk("stall_cnt", OW'(stall_cnt), OW'(m_stall));
    chk("flush_cnt", OW'(flush_cnt), OW'(m_flush));
  endtask

  initial begin
    m_valid = 1'b0; m_dmrd = 1'b0; m_rd = 5'd0; m_stall = '0; m_flush = '0;
    rst = 1'b1; flush_i = 1'b0;
    rand_d();
    tick();
    rand_d();
    tick();
    chk("rst_valid", OW'(valid_E), '0);
    chk("rst_stall", OW'(stall_o), '0);
    rst = 1'b0;

    // add x3,x1,x2 passes straight through
    set_instr(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'h40);
    tick();
    chk("pass_ruwr", OW'(RUWr_E), OW'(1));
    chk("pass_rd", OW'(rd_E), OW'(3));
    chk("pass_pc", OW'(PC_E), OW'(32'h40));
    chk("pass_valid", OW'(valid_E), OW'(1));

    // lw x5 then add x6,x5,x7: one bubble, then the add enters E
    set_instr(1'b1, 1'b1, 1'b1, 5'd5, 5'd2, 5'd0, 32'h44);
    tick();
    set_instr(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd7, 32'h48);
    #2;
    chk("lu_stall_hi", OW'(stall_o), OW'(1));
    tick();
    chk("lu_bubble_valid", OW'(valid_E), '0);
    chk("lu_bubble_ruwr", OW'(RUWr_E), '0);
    chk("lu_stall_lo", OW'(stall_o), '0);
    tick();
    chk("lu_add_rd", OW'(rd_E), OW'(6));
    chk("lu_add_valid", OW'(valid_E), OW'(1));
    chk("lu_stall_cnt", OW'(stall_cnt), OW'(1));

    // lw x0 never stalls a consumer of x0
    set_instr(1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 5'd0, 32'h4c);
    tick();
    set_instr(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0, 32'h50);
    #2;
    chk("x0_stall", OW'(stall_o), '0);
    tick();
    chk("x0_valid", OW'(valid_E), OW'(1));

    // flush beats a simultaneous load-use hazard
    set_instr(1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd0, 32'h54);
    tick();
    set_instr(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd7, 32'h58);
    flush_i = 1'b1;
    #2;
    chk("fl_stall", OW'(stall_o), '0);
    tick();
    flush_i = 1'b0;
    chk("fl_valid", OW'(valid_E), '0);
    chk("fl_flush_cnt", OW'(flush_cnt), OW'(1));
    chk("fl_stall_cnt", OW'(stall_cnt), OW'(1));

    // invalid slot with write/branch controls set must not carry them
    rand_d();
    valid_D = 1'b0; RUWr_D = 1'b1; DMWr_D = 1'b1; BrOp_D = 5'd9;
    tick();
    chk("inv_ruwr", OW'(RUWr_E), '0);
    chk("inv_brop", OW'(BrOp_E), '0);

    for (int i = 0; i < 40; i++) begin
      rand_d();
      flush_i = ($urandom_range(0, 7) == 0);
      tick();
    end
    flush_i = 1'b0;

    // reset in the middle of a stall clears everything
    set_instr(1'b1, 1'b1, 1'b1, 5'd4, 5'd1, 5'd0, 32'h60);
    tick();
    set_instr(1'b1, 1'b1, 1'b0, 5'd6, 5'd4, 5'd4, 32'h64);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", OW'(valid_E), '0);
    chk("mid_rst_stall_cnt", OW'(stall_cnt), '0);

    // flush counter saturates at all-ones
    for (int i = 0; i < 20; i++) begin
      rand_d();
      flush_i = 1'b1;
      tick();
    end
    flush_i = 1'b0;
    chk("sat_flush_cnt", OW'(flush_cnt), OW'(15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register of the segmented RV32I core. It captures the control bundle produced by the control unit, together with the decoded operands, immediate and register indices, and presents them to the execute stage one cycle later. It also owns load-use hazard detection: it freezes PC and IF/ID, and it inserts a bubble into execute. On a taken branch or jump resolved in execute, it squashes the decode instruction. Two saturating event counters (stall, flush) support performance debug.

## Interface
Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- valid_D  in  1  decode slot holds a real instruction.
- RUWr_D, AluASrc_D, AluBSrc_D, DMWr_D, DMRd_D  in  1 each  control-unit outputs.
- BrOp_D  in  5  branch operation.
- ALUOp_D  in  4  ALU operation.
- DMCtrl_D  in  3  memory access size/sign.
- RUDataWrSrc_D  in  2  writeback source select.
- PC_D, RUrs1_D, RUrs2_D, ImmExt_D  in  XLEN each  PC, register-file read data, sign-extended immediate.
- rs1_D, rs2_D, rd_D  in  5 each  register indices.
- flush_i  in  1  taken branch/jump resolved in execute (NextPCSrc).
- All `_D` fields above  out  same widths, renamed `_E`  registered copies.
- valid_E  out  1  execute slot holds a real instruction.
- stall_o  out  1  combinational; holds PC and IF/ID this cycle.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

## Operation
- **Hazard detection** (combinational on current E and D contents):
  - hazard = valid_E & DMRd_E & (rd_E != 0) & valid_D & ((rd_E == rs1_D) | (rd_E == rs2_D)).
  - Both source indices are compared unconditionally. Conservative false stalls on instructions that do not use rs2 (I-type, lui, jal) are accepted.
  - stall_o = hazard & ~flush_i.
- **Register update**, in priority order each rising clk:
  1. rst: all `_E` outputs ← 0, valid_E ← 0, both counters ← 0.
  2. flush_i: bubble. valid_E ← 0; RUWr_E, DMWr_E, DMRd_E ← 0; BrOp_E ← 0; all other `_E` fields ← 0.
  3. hazard: bubble, identical to the flush bubble.
  4. Otherwise: every `_E` ← its `_D` input, and valid_E ← valid_D.
  - If valid_D = 0 in case 4, the control fields RUWr, DMWr, DMRd and BrOp are still forced to 0, so an invalid slot never writes state or redirects PC.
- **Bubble encoding**: a bubble is the all-zero control word. It is architecturally a nop: no register write, no memory access, no branch.
- **Counters**:
  - stall_cnt +1 on every cycle where case 3 is taken.
  - flush_cnt +1 on every cycle where flush_i = 1 and rst = 0.
  - Both saturate at 2^CNT_W−1 and never wrap.
- **Simultaneous flush and hazard**: flush wins. stall_o = 0, stall_cnt is not incremented, and flush_cnt is incremented.
- The block never holds its own contents. During a stall the decode instruction stays in IF/ID (upstream freeze), and the execute slot receives a bubble. The load therefore advances to memory and the dependent instruction re-evaluates the hazard next cycle, finding none.

## Timing
- Latency D→E: 1 cycle, with registered outputs only.
- Reset values:
  - All `_E` = 0 and valid_E = 0.
  - stall_cnt = flush_cnt = 0.
  - stall_o = 0, because valid_E = 0 after reset.
- stall_o is valid in the same cycle as the offending D/E contents. It is combinational from the E-stage registers and rs1_D/rs2_D/valid_D/flush_i, with no path from other `_D` data.
- A load-use pair produces exactly one stall cycle, and then the consumer enters E on the next clock.
- rst asserted mid-stall or mid-flush clears everything on that edge. The first post-reset cycle is a bubble in E.
- Counter saturation is checked on the same edge as the increment, so the counter holds at all-ones.

## Test plan
- **Reset**: rst = 1 for 2 cycles with random `_D` inputs → all `_E` outputs 0, valid_E = 0, stall_o = 0, both counters 0.
- **Pass-through**: add x3,x1,x2 (RUWr_D = 1, ALUOp_D = 0, rd_D = 3, PC_D = 0x40, valid_D = 1) → one cycle later RUWr_E = 1, rd_E = 3, PC_E = 0x40, valid_E = 1, and stall_o stays 0.
- **Load-use**: lw x5 in E (DMRd_E = 1, rd_E = 5), then add x6,x5,x7 in D → stall_o = 1 for exactly 1 cycle. The next E is a bubble (RUWr_E = 0, valid_E = 0), the add reaches E on the following edge, and stall_cnt = 1.
- **x0 destination**: lw x0 followed by a consumer of x0 → stall_o = 0 and no bubble.
- **Flush priority**: flush_i = 1 in the same cycle as a load-use hazard → stall_o = 0, E receives a bubble, flush_cnt +1, and stall_cnt unchanged.
- **Saturation**: with CNT_W = 4, force 20 consecutive flushes → flush_cnt = 15 and holds at 15.
